boot_loader_ctrl: RTL and testbench
===================================

# boot_loader_ctrl

Boot sequencer for the single-cycle RISC-V core. It holds the CPU in reset, receives a program image as a byte stream over a valid/ready handshake, and assembles little-endian 32-bit words into instruction memory. It then releases the CPU `Reset` after a programmable hold period. It sits between the board-level byte source (UART receiver) and the CPU/instruction-memory pair, and its `cpu_reset` output drives the CPU's `Reset` input.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `RESET_HOLD`, 4: cycles `cpu_reset` stays high after the last write; must be ≥1.

- `clk`  in  1  single clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming image byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block accepts a byte; a transfer occurs when `rx_valid && rx_ready` at a rising edge.
- `reload`  in  1  one-cycle request to reload the image; honoured only in RUN or ERROR.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  word to write.
- `cpu_reset`  out  1  drives CPU `Reset`; high everywhere except RUN.
- `boot_done`  out  1  high in RUN.
- `boot_error`  out  1  high in ERROR.
- `words_loaded`  out  16  count of words written since the last load start.

## Operation
- Image format, in order:
  - length N as 16-bit little-endian (LEN_LO, LEN_HI);
  - 4·N data bytes, each word little-endian (byte i goes to bits [8i+7:8i]);
  - a checksum byte, only when the macro is defined.
- States: LEN_LO → LEN_HI → DATA → (CHECK) → HOLD → RUN; ERROR.
- `rx_ready` is combinational: high in LEN_LO, LEN_HI, DATA and CHECK. It is low in HOLD, RUN and ERROR, and low whenever `Reset` is high.
- LEN_HI transfer:
  - if N > 2^ADDR_W, go to ERROR;
  - if N == 0, go to CHECK (macro on) or HOLD;
  - otherwise go to DATA.
- DATA:
  - a 2-bit byte counter places each byte in its lane;
  - on the 4th byte, register `imem_we`=1, `imem_wdata`=assembled word and `imem_addr`=word index (starting at 0); increment `words_loaded`;
  - after word N−1, go to CHECK or HOLD.
- HOLD: a down-counter is loaded with RESET_HOLD on entry. When it expires, go to RUN.
- RUN: `cpu_reset`=0 and `boot_done`=1. `reload` returns to LEN_LO.
- ERROR: `boot_error`=1 and `cpu_reset`=1. It is left only via `reload` (to LEN_LO, clearing `boot_error`) or `Reset`.
- `reload` in any other state is ignored.
- Every entry to LEN_LO clears `words_loaded`, the byte counter, the word address and the checksum accumulator.
- Reset values:
  - state LEN_LO;
  - `cpu_reset`=1;
  - `imem_we`, `imem_addr`, `imem_wdata`, `boot_done`, `boot_error` and `words_loaded` all 0.
- Reset mid-load discards any partial word. Words already written stay in memory but will be overwritten by the next load.

## Timing
- `imem_we` is a registered pulse, high for exactly the cycle after the 4th byte of a word is accepted. `imem_addr`/`imem_wdata` are stable in that cycle.
- A maximum-rate stream (one byte per cycle) is never back-pressured during load.
- Last word write occurs in the first HOLD cycle. `cpu_reset` falls at the edge entering RUN, exactly RESET_HOLD cycles after HOLD entry.
- `reload` sampled high in RUN: `cpu_reset`=1 and `boot_done`=0 from the next cycle; `rx_ready`=1 the same next cycle.
- `Reset` has priority over `reload` and over a simultaneous byte transfer.
- `boot_done`, `boot_error` and `cpu_reset` are registered; there are no glitches.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - CHECK state exists; one extra byte c follows the data;
  - an 8-bit accumulator sums every accepted byte (length plus data) mod 256;
  - if c == sum, go to HOLD; otherwise go to ERROR with no further writes.
- Undefined: CHECK is absent, the accumulator is not synthesised, and DATA/LEN_HI go directly to HOLD.

## Test plan
- N=2, bytes 02 00 93 00 50 00 13 01 10 00, RESET_HOLD=4, one byte per cycle → imem write (0, 0x00500093) then (1, 0x00100113), `words_loaded`=2, `cpu_reset` falls 4 cycles after HOLD entry, `boot_done`=1.
- Same image with `rx_valid` toggling every other cycle → identical writes. In RUN, hold `rx_valid`=1 → `rx_ready`=0, no `imem_we`.
- ADDR_W=8, length bytes 01 01 (N=257) → ERROR after LEN_HI, `boot_error`=1, `cpu_reset`=1, zero writes. `reload` then resends a valid image → normal boot.
- `Reset` after 5 data bytes → next cycle state LEN_LO, `imem_we`=0, `words_loaded`=0. Resending the full image rewrites from address 0.
- `reload` pulse in RUN → `cpu_reset`=1 and `boot_done`=0 next cycle. New N=1 image 13 00 00 00 → write (0, 0x00000013), reboot.
- With `BOOT_CHECKSUM_EN`: 01 00 13 00 00 00 followed by 14 → RUN. Followed by 15 → ERROR, `cpu_reset` stays 1.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: loads a length-prefixed little-endian byte image into instruction
// memory, then releases the CPU reset after RESET_HOLD cycles. Define BOOT_CHECKSUM_EN
// to require a trailing mod-256 checksum byte before the CPU is released.
module boot_loader_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
`ifdef BOOT_CHECKSUM_EN
    S_CHECK  = 3'd3,
`endif
    S_HOLD   = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  // Largest legal length is 2^ADDR_W, which needs one bit more than the length field.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHECK;
`else
  localparam state_t S_AFTER_DATA = S_HOLD;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_len_lo;
  logic [15:0]         r_len;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_word_buf;
  logic [ADDR_W-1:0]   r_word_addr;
  logic [15:0]         r_words_loaded;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_cpu_reset;
  logic                r_boot_done;
  logic                r_boot_error;

  logic                w_loading;
  logic                w_xfer;
  logic [15:0]         w_len_full;
  logic                w_word_done;
  logic                w_last_word;
  logic                w_enter_len_lo;
  logic                w_enter_hold;

  assign w_loading = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                  || (r_state == S_CHECK)
`endif
                  ;

  assign rx_ready       = w_loading && !Reset;
  assign w_xfer         = rx_valid && rx_ready;
  assign w_len_full     = {rx_data, r_len_lo};
  assign w_word_done    = w_xfer && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
  assign w_last_word    = (r_words_loaded + 16'd1) == r_len;
  assign w_enter_len_lo = (w_next == S_LEN_LO) && (r_state != S_LEN_LO);
  assign w_enter_hold   = (w_next == S_HOLD) && (r_state != S_HOLD);

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk) begin
    if (Reset || w_enter_len_lo) begin
      r_csum <= 8'h00;
    end else if (w_xfer && (r_state != S_CHECK)) begin
      r_csum <= r_csum + rx_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_LEN_LO;
    end else begin
      // NOTE: state and datapath registers use non-blocking assignments so every
      // always_ff reads the pre-edge values regardless of simulator evaluation order.
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_LEN_LO: if (w_xfer) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_xfer) begin
          if ({1'b0, w_len_full} > MAX_WORDS) w_next = S_ERROR;
          else if (w_len_full == 16'd0)       w_next = S_AFTER_DATA;
          else                                w_next = S_DATA;
        end
      end
      S_DATA: if (w_word_done && w_last_word) w_next = S_AFTER_DATA;
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (w_xfer) w_next = (rx_data == r_csum) ? S_HOLD : S_ERROR;
      end
`endif
      S_HOLD:  if (r_hold_cnt == HOLD_W'(1)) w_next = S_RUN;
      S_RUN:   if (reload) w_next = S_LEN_LO;
      S_ERROR: if (reload) w_next = S_LEN_LO;
      default: w_next = S_LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_len_lo       <= 8'h00;
      r_len          <= 16'h0000;
      r_byte_cnt     <= 2'd0;
      r_word_buf     <= 24'h000000;
      r_word_addr    <= '0;
      r_words_loaded <= 16'h0000;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= 32'h0000_0000;
    end else begin
      r_imem_we <= 1'b0;
      if (w_enter_len_lo) begin
        r_byte_cnt     <= 2'd0;
        r_word_addr    <= '0;
        r_words_loaded <= 16'h0000;
      end else if (w_xfer) begin
        unique case (r_state)
          S_LEN_LO: r_len_lo <= rx_data;
          S_LEN_HI: r_len    <= w_len_full;
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            unique case (r_byte_cnt)
              2'd0: r_word_buf[7:0]   <= rx_data;
              2'd1: r_word_buf[15:8]  <= rx_data;
              2'd2: r_word_buf[23:16] <= rx_data;
              default: begin
                r_imem_we      <= 1'b1;
                r_imem_wdata   <= {rx_data, r_word_buf};
                r_imem_addr    <= r_word_addr;
                r_word_addr    <= r_word_addr + ADDR_W'(1);
                r_words_loaded <= r_words_loaded + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Hold timer: loaded on HOLD entry so RUN is entered exactly RESET_HOLD edges later.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_hold_cnt <= '0;
    end else if (w_enter_hold) begin
      r_hold_cnt <= HOLD_W'(RESET_HOLD);
    end else if (r_state == S_HOLD) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cpu_reset  <= 1'b1;
      r_boot_done  <= 1'b0;
      r_boot_error <= 1'b0;
    end else begin
      r_cpu_reset  <= (w_next != S_RUN);
      r_boot_done  <= (w_next == S_RUN);
      r_boot_error <= (w_next == S_ERROR);
    end
  end

  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign boot_done    = r_boot_done;
  assign boot_error   = r_boot_error;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: directed and random images compared
// against a byte-level model of the image format and boot timing.
module tb_boot_loader_ctrl;
  localparam int ADDR_W     = 8;
  localparam int RESET_HOLD = 4;
  localparam int MAX_WAIT   = 64;
  localparam int MAX_WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              Reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              boot_done;
  logic              boot_error;
  logic [15:0]       words_loaded;

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .RESET_HOLD(RESET_HOLD)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .boot_done    (boot_done),
    .boot_error   (boot_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          edge_n;
  } wr_t;

  wr_t        wr_q[$];
  int         cyc = 0;
  int         last_fall = -1;
  logic       prev_cpu_reset = 1'b1;

  int         n_pass = 0;
  int         n_total = 0;
  int         stalls = 0;
  int         last_accept = 0;
  int         last_data_accept = -1;
  logic [7:0] img[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/reset-release monitor; edge_n is the index of the edge that produced the value.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_q.push_back('{int'(imem_addr), imem_wdata, cyc});
    if (prev_cpu_reset === 1'b1 && cpu_reset === 1'b0) last_fall = cyc;
    prev_cpu_reset = cpu_reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Presents one byte after 'gap' idle cycles; returns just before the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited != 0) stalls++;
    last_accept = cyc + 1;
  endtask

  task automatic append_csum();
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (img[i]) s = s + img[i];
    img.push_back(s);
`endif
  endtask

  task automatic rand_image(input int n);
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    append_csum();
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    reload   = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_boot_done"}, 32'(boot_done), 32'd0);
    check({tag, "_boot_error"}, 32'(boot_error), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Sends img (gap<0: random 0..3 idle cycles per byte), optionally pulsing reload
  // before byte index reload_at (== byte count: pulse during HOLD), then checks the
  // outcome against the image-format rules.
  task automatic load_and_check(input string tag, input int gap, input int reload_at);
    int n, base, nbytes, exp_writes, waited, got;
    bit len_err, ok;
    logic [31:0] exp_word;
    n       = int'({img[1], img[0]});
    len_err = n > MAX_WORDS;
    nbytes  = len_err ? 2 : img.size();
    ok      = !len_err;
`ifdef BOOT_CHECKSUM_EN
    if (!len_err) begin
      logic [7:0] sum;
      sum = 8'h00;
      for (int i = 0; i < nbytes - 1; i++) sum = sum + img[i];
      ok = (sum == img[nbytes-1]);
    end
`endif
    exp_writes       = len_err ? 0 : n;
    base             = wr_q.size();
    stalls           = 0;
    last_data_accept = -1;
    for (int i = 0; i < nbytes; i++) begin
      if (i == reload_at) begin
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
      send_byte(img[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
      if (i == 4 * n + 1) last_data_accept = last_accept;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    if (reload_at == nbytes) begin
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
    end
    waited = 0;
    while (boot_done !== 1'b1 && boot_error !== 1'b1 && waited < RESET_HOLD + 16) begin
      @(negedge clk);
      waited++;
    end
    #1;
    got = wr_q.size() - base;
    check({tag, "_stalls"}, 32'(stalls), 32'd0);
    check({tag, "_nwrites"}, 32'(got), 32'(exp_writes));
    for (int k = 0; k < exp_writes && k < got; k++) begin
      exp_word = {img[2+4*k+3], img[2+4*k+2], img[2+4*k+1], img[2+4*k]};
      check($sformatf("%s_addr%0d", tag, k), 32'(wr_q[base+k].addr), 32'(k));
      check($sformatf("%s_data%0d", tag, k), wr_q[base+k].data, exp_word);
    end
    if (exp_writes > 0 && got >= exp_writes)
      check({tag, "_last_write_edge"}, 32'(wr_q[base+exp_writes-1].edge_n), 32'(last_data_accept));
    if (ok) begin
      check({tag, "_boot_done"}, 32'(boot_done), 32'd1);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
      check({tag, "_boot_error"}, 32'(boot_error), 32'd0);
      check({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_release_edge"}, 32'(last_fall), 32'(last_accept + RESET_HOLD));
    end else begin
      check({tag, "_boot_error"}, 32'(boot_error), 32'd1);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, "_boot_done"}, 32'(boot_done), 32'd0);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    end
  endtask

  initial begin
    int n0;
    Reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_boot_done", 32'(boot_done), 32'd0);
    check("rst_boot_error", 32'(boot_error), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    Reset = 1'b0;
    @(negedge clk);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Reference image, maximum rate.
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    append_csum();
    base_check: begin
      n0 = wr_q.size();
      load_and_check("plan_fast", 0, -1);
      if (wr_q.size() >= n0 + 2) begin
        check("plan_word0", wr_q[n0].data, 32'h0050_0093);
        check("plan_word1", wr_q[n0+1].data, 32'h0010_0113);
      end
    end

    // Bytes offered in RUN are refused and cause no writes.
    n0 = wr_q.size();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (6) @(negedge clk);
    check("run_rx_ready", 32'(rx_ready), 32'd0);
    #1;
    check("run_no_writes", 32'(wr_q.size() - n0), 32'd0);
    check("run_still_done", 32'(boot_done), 32'd1);
    rx_valid = 1'b0;

    do_reload("reload_run");
    load_and_check("plan_toggle", 1, -1);

    // Oversized length goes to ERROR with no writes; reload recovers.
    do_reload("reload_2");
    img = '{8'h01, 8'h01};
    load_and_check("len257", 0, -1);
    do_reload("reload_err");
    rand_image(3);
    load_and_check("after_err", -1, -1);

    // Reset after five data bytes discards the partial load.
    do_reload("reload_3");
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    append_csum();
    for (int i = 0; i < 7; i++) send_byte(img[i], 0);
    @(negedge clk);
    check("midload_words", 32'(words_loaded), 32'd1);
    Reset   = 1'b1;
    rx_data = img[7];
    #1;
    check("midload_rx_ready_in_reset", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("midload_imem_we", 32'(imem_we), 32'd0);
    check("midload_words_cleared", 32'(words_loaded), 32'd0);
    check("midload_cpu_reset", 32'(cpu_reset), 32'd1);
    Reset    = 1'b0;
    rx_valid = 1'b0;
    load_and_check("after_reset", 0, -1);

    // Single-word image.
    do_reload("reload_4");
    img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    append_csum();
    n0 = wr_q.size();
    load_and_check("n1", 0, -1);
    if (wr_q.size() > n0) check("n1_word", wr_q[n0].data, 32'h0000_0013);

    // reload outside RUN/ERROR is ignored.
    do_reload("reload_5");
    rand_image(3);
    load_and_check("reload_in_data", 0, 6);
    do_reload("reload_6");
    rand_image(2);
    load_and_check("reload_in_hold", 0, img.size());

    // Empty image and full-capacity image.
    do_reload("reload_7");
    img = '{8'h00, 8'h00};
    append_csum();
    load_and_check("n0", 0, -1);
    do_reload("reload_8");
    rand_image(MAX_WORDS);
    load_and_check("nmax", 0, -1);

    for (int r = 0; r < 4; r++) begin
      do_reload($sformatf("reload_rand%0d", r));
      rand_image(int'($urandom_range(1, 12)));
      load_and_check($sformatf("rand%0d", r), -1, -1);
    end

`ifdef BOOT_CHECKSUM_EN
    do_reload("reload_cs1");
    img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    load_and_check("csum_ok", 0, -1);
    do_reload("reload_cs2");
    img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h15};
    load_and_check("csum_bad", 0, -1);
    repeat (RESET_HOLD + 2) @(negedge clk);
    check("csum_bad_cpu_reset_held", 32'(cpu_reset), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
